// File: rtl/osc_freq_meter.sv
// osc_freq_meter: settles a ring oscillator, then counts its rising edges
// over a programmable gate window of wb_clk_i cycles and reports the count.
// Ports: wb_clk_i clock; wb_rst_n sync active-low reset; start request;
//   win_len gate length; osc_in async oscillator; osc_en oscillator enable;
//   busy not idle; done result pulse; count/ovf last result and saturation.
// Option: define OSC_FREQ_METER_CONT_EN to add input cont, which chains
//   back-to-back gate windows without re-settling.
module osc_freq_meter #(
   parameter int CNT_W         = 16,
   parameter int WIN_W         = 16,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_n,
   input  logic             start,
   input  logic [WIN_W-1:0] win_len,
   input  logic             osc_in,
`ifdef OSC_FREQ_METER_CONT_EN
   input  logic             cont,
`endif
   output logic             osc_en,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] count,
   output logic             ovf
);

   localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      COUNT,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic             s1, s2, s3;
   logic             rise;
   logic [ST_W-1:0]  stmr;
   logic [WIN_W-1:0] wlen, wtmr;
   logic [CNT_W-1:0] acc, acc_nxt;
   logic             sat, sat_nxt;
   logic             settle_end, win_end, cont_go;

`ifdef OSC_FREQ_METER_CONT_EN
   assign cont_go = cont;
`else
   assign cont_go = 1'b0;
`endif

   // s1/s2 form the synchroniser; s3 only delays s2 for edge detection
   assign rise       = s2 & ~s3;
   assign settle_end = (stmr == ST_LAST);
   // a zero-length window still gets one counting cycle
   assign win_end    = (wlen == '0) || (wtmr == wlen - WIN_W'(1));

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n) state <= IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = SETTLE;
         end
         SETTLE: if (settle_end) state_nxt = COUNT;
         COUNT:  if (win_end) state_nxt = DONE;
         DONE: begin
            done      = 1'b1;
            state_nxt = cont_go ? COUNT : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // saturating accumulate; sat marks an edge lost at all-ones
   always_comb begin
      acc_nxt = acc;
      sat_nxt = sat;
      if (rise) begin
         if (&acc) sat_nxt = 1'b1;
         else      acc_nxt = acc + CNT_W'(1);
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n) begin
         {s3, s2, s1} <= 3'b000;
         stmr   <= '0;
         wlen   <= '0;
         wtmr   <= '0;
         acc    <= '0;
         sat    <= 1'b0;
         osc_en <= 1'b0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         {s3, s2, s1} <= {s2, s1, osc_in};
         unique case (state)
            IDLE: begin
               if (start) begin
                  wlen   <= win_len;
                  stmr   <= '0;
                  osc_en <= 1'b1;
               end
            end
            SETTLE: begin
               stmr <= stmr + ST_W'(1);
               if (settle_end) begin
                  acc  <= '0;
                  sat  <= 1'b0;
                  wtmr <= '0;
               end
            end
            COUNT: begin
               acc  <= acc_nxt;
               sat  <= sat_nxt;
               wtmr <= wtmr + WIN_W'(1);
               // publish so the result is valid while done is high
               if (win_end) begin
                  count <= acc_nxt;
                  ovf   <= sat_nxt;
               end
            end
            DONE: begin
               if (cont_go) begin
                  acc  <= '0;
                  sat  <= 1'b0;
                  wtmr <= '0;
               end else begin
                  osc_en <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_osc_freq_meter.sv
// tb_osc_freq_meter: table vectors, random runs against an edge-count
// model, plus reset, abort and continuous-mode sequences.
module tb_osc_freq_meter;

   localparam int S = 16;

   logic        clk = 1'b0;
   logic        rst_n, start, osc_in;
   logic [15:0] win_len;
   logic        en_a, busy_a, done_a, ovf_a;
   logic [15:0] cnt_a;
   logic        en_b, busy_b, done_b, ovf_b;
   logic [3:0]  cnt_b;
`ifdef OSC_FREQ_METER_CONT_EN
   logic        cont;
`endif

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   osc_freq_meter #(.CNT_W(16), .WIN_W(16), .SETTLE_CYCLES(S)) dut_a (
      .wb_clk_i(clk),
      .wb_rst_n(rst_n),
      .start(start),
      .win_len(win_len),
      .osc_in(osc_in),
`ifdef OSC_FREQ_METER_CONT_EN
      .cont(cont),
`endif
      .osc_en(en_a),
      .busy(busy_a),
      .done(done_a),
      .count(cnt_a),
      .ovf(ovf_a)
   );

   osc_freq_meter #(.CNT_W(4), .WIN_W(16), .SETTLE_CYCLES(S)) dut_b (
      .wb_clk_i(clk),
      .wb_rst_n(rst_n),
      .start(start),
      .win_len(win_len),
      .osc_in(osc_in),
`ifdef OSC_FREQ_METER_CONT_EN
      .cont(cont),
`endif
      .osc_en(en_b),
      .busy(busy_b),
      .done(done_b),
      .count(cnt_b),
      .ovf(ovf_b)
   );

   int    n_chk = 0;
   int    n_pass = 0;
   string tag = "";
   bit    oh [0:99999];
   int    osc_mode = 0;
   int    osc_p = 1;
   int    osc_t0 = 0;
   int    hold = 0;

   typedef struct {
      int w;
      int mode;
      int p;
      bit spam;
      int e;
      int cb;
      bit ob;
   } vec_t;

   vec_t tab [10];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s %s: got %0d want %0d", tag, name, act, exp);
   endtask

   // one clock: wait for the falling edge, then drive this cycle's osc_in
   task automatic cyc_step();
      @(negedge clk);
      case (osc_mode)
         0: osc_in = 1'b0;
         1: osc_in = 1'b1;
         2: osc_in = (((cyc - osc_t0) % osc_p) < osc_p / 2) ? 1'b1 : 1'b0;
         default: begin
            if (hold == 0) begin
               osc_in = ~osc_in;
               hold   = $urandom_range(1, 5);
            end else begin
               hold--;
            end
         end
      endcase
      oh[cyc] = osc_in;
   endtask

   // rises seen after the 2-flop sync during the gate window
   function automatic int model_edges(input int t, input int w);
      int n;
      int wl;
      n  = 0;
      wl = (w == 0) ? 1 : w;
      for (int c = t + 1 + S; c <= t + S + wl; c++)
         if (oh[c-2] && !oh[c-3]) n++;
      return n;
   endfunction

   task automatic measure(input int w, input int mode, input int p,
                          input bit spam, input int e_in, input int cb_in,
                          input bit ob_in);
      int t, wl, dexp, da, db, e, cb, redo;
      bit ob;
      wl       = (w == 0) ? 1 : w;
      osc_mode = mode;
      osc_p    = p;
      osc_t0   = cyc + 1;
      cyc_step();
      start   = 1'b1;
      win_len = 16'(w);
      t       = cyc;
      dexp    = t + 1 + S + wl;
      cyc_step();
      start = spam;
      chk("en_rise_a", en_a, 1);
      chk("en_rise_b", en_b, 1);
      chk("busy_a", busy_a, 1);
      da = -1;
      db = -1;
      for (int i = 0; i < wl + S + 20; i++) begin
         if (da < 0 && done_a) da = cyc;
         if (db < 0 && done_b) db = cyc;
         if (da >= 0 && db >= 0) break;
         cyc_step();
         start = spam && cyc <= dexp && $urandom_range(0, 1) == 1;
      end
      chk("done_at_a", da - t, dexp - t);
      chk("done_at_b", db - t, dexp - t);
      cyc_step();
      start = 1'b0;
      e  = e_in;
      cb = cb_in;
      ob = ob_in;
      if (e < 0) begin
         e  = model_edges(t, w);
         cb = (e > 15) ? 15 : e;
         ob = e > 15;
      end
      chk("count_a", cnt_a, e);
      chk("ovf_a", ovf_a, 0);
      chk("count_b", cnt_b, cb);
      chk("ovf_b", ovf_b, ob);
      chk("en_off_a", en_a, 0);
      chk("en_off_b", en_b, 0);
      chk("idle_a", busy_a, 0);
      if (spam) begin
         redo = 0;
         repeat (S + 5) begin
            cyc_step();
            if (done_a || busy_a || done_b) redo++;
         end
         chk("no_redo", redo, 0);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      win_len = '0;
      osc_in  = 1'b0;
`ifdef OSC_FREQ_METER_CONT_EN
      cont = 1'b0;
`endif

      tab[0] = '{100, 2, 4, 1'b0, 25, 15, 1'b1};
      tab[1] = '{0, 0, 1, 1'b1, 0, 0, 1'b0};
      tab[2] = '{20, 1, 1, 1'b0, 0, 0, 1'b0};
      tab[3] = '{50, 2, 5, 1'b0, 10, 10, 1'b0};
      tab[4] = '{30, 2, 3, 1'b1, 10, 10, 1'b0};
      tab[5] = '{1, 2, 5, 1'b0, 1, 1, 1'b0};
      tab[6] = '{2, 2, 17, 1'b0, 0, 0, 1'b0};
      tab[7] = '{3, 2, 17, 1'b0, 1, 1, 1'b0};
      tab[8] = '{60, 2, 4, 1'b0, 15, 15, 1'b0};
      tab[9] = '{64, 2, 4, 1'b0, 16, 15, 1'b1};

      tag      = "reset";
      osc_mode = 3;
      repeat (3) cyc_step();
      chk("en_a", en_a, 0);
      chk("busy_a", busy_a, 0);
      chk("done_a", done_a, 0);
      chk("count_a", cnt_a, 0);
      chk("ovf_a", ovf_a, 0);
      chk("en_b", en_b, 0);
      chk("count_b", cnt_b, 0);
      chk("ovf_b", ovf_b, 0);
      rst_n = 1'b1;
      repeat (2) cyc_step();

      for (int i = 0; i < 10; i++) begin
         tag = $sformatf("vec%0d", i);
         measure(tab[i].w, tab[i].mode, tab[i].p, tab[i].spam,
                 tab[i].e, tab[i].cb, tab[i].ob);
         repeat (2) cyc_step();
      end

      tag      = "abort";
      osc_mode = 2;
      osc_p    = 4;
      osc_t0   = cyc + 1;
      cyc_step();
      start   = 1'b1;
      win_len = 16'd100;
      repeat (25) begin
         cyc_step();
         start = 1'b0;
      end
      chk("pre_busy", busy_a, 1);
      rst_n = 1'b0;
      cyc_step();
      chk("en_a", en_a, 0);
      chk("busy_a", busy_a, 0);
      chk("count_a", cnt_a, 0);
      chk("count_b", cnt_b, 0);
      chk("ovf_b", ovf_b, 0);
      chk("en_b", en_b, 0);
      rst_n = 1'b1;
      repeat (2) cyc_step();

      for (int i = 0; i < 20; i++) begin
         tag = $sformatf("rnd%0d", i);
         measure($urandom_range(0, 200), 3, 1, 1'($urandom_range(0, 1)),
                 -1, 0, 1'b0);
         repeat ($urandom_range(1, 4)) cyc_step();
      end

`ifdef OSC_FREQ_METER_CONT_EN
      begin
         int nd, drop, tt;
         int dc [3];
         tag      = "cont";
         nd       = 0;
         drop     = 0;
         dc       = '{-1, -1, -1};
         cont     = 1'b1;
         osc_mode = 2;
         osc_p    = 5;
         osc_t0   = cyc + 1;
         cyc_step();
         start   = 1'b1;
         win_len = 16'd50;
         tt      = cyc;
         for (int i = 0; i < 250 && nd < 3; i++) begin
            cyc_step();
            start = 1'b0;
            if (nd > 0 && cyc == dc[nd-1] + 1) chk("cnt_run", cnt_a, 10);
            if (nd == 2 && cyc == dc[1] + 1) cont = 1'b0;
            if (!en_a) drop++;
            if (done_a) begin
               dc[nd] = cyc;
               nd++;
            end
         end
         chk("done0", dc[0] - tt, 67);
         chk("done1", dc[1] - tt, 118);
         chk("done2", dc[2] - tt, 169);
         chk("en_drop", drop, 0);
         cyc_step();
         chk("cnt_last", cnt_a, 10);
         chk("en_off", en_a, 0);
         chk("idle", busy_a, 0);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
